// File: rtl/regfile_dump_if.sv
// regfile_dump_if: regfile read port, control and valid/ready stream bundle for regfile_dump
interface regfile_dump_if;
  logic        start;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_chk;
  modport master (
    input  start, rf_data, out_ready,
    output rf_addr, busy, done, out_valid, out_addr, out_data, out_last, out_chk
  );
  modport slave (
    output start, rf_data, out_ready,
    input  rf_addr, busy, done, out_valid, out_addr, out_data, out_last, out_chk
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: streams x0..x31 over valid/ready; REGFILE_DUMP_CRC_EN appends an XOR checksum word
module regfile_dump (
  input logic            clk,
  input logic            rst,
  regfile_dump_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2, S_DONE = 2'd3;
`ifdef REGFILE_DUMP_CRC_EN
  localparam logic [5:0] LAST = 6'd32;
`else
  localparam logic [5:0] LAST = 6'd31;
`endif
  logic [1:0]  r_state;
  logic [5:0]  r_idx;
  logic [63:0] r_data;
  logic [4:0]  r_addr;
  logic [63:0] w_load;
  logic        w_last;
  assign w_last        = r_state == S_SEND && r_idx == LAST;
  assign bus.rf_addr   = r_state == S_LOAD ? r_idx[4:0] : 5'd0;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.done      = r_state == S_DONE;
  assign bus.out_valid = r_state == S_SEND;
  assign bus.out_addr  = r_addr;
  assign bus.out_data  = r_data;
  assign bus.out_last  = w_last;
`ifdef REGFILE_DUMP_CRC_EN
  logic [63:0] r_chk;
  // idx 32 is the checksum slot: its out_addr wraps to 0 via idx[4:0]
  assign bus.out_chk = r_state == S_SEND && r_idx[5];
  assign w_load      = r_idx[5] ? r_chk : bus.rf_data;
  always_ff @(posedge clk) begin
    if (rst) r_chk <= '0;
    else if (r_state == S_IDLE && bus.start) r_chk <= '0;
    else if (r_state == S_LOAD && !r_idx[5]) r_chk <= r_chk ^ bus.rf_data;
  end
`else
  assign bus.out_chk = 1'b0;
  assign w_load      = bus.rf_data;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_idx   <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_data  <= w_load;
          r_addr  <= r_idx[4:0];
          r_state <= S_SEND;
        end
        S_SEND: if (bus.out_ready) begin
          r_state <= w_last ? S_DONE : S_LOAD;
          r_idx   <= w_last ? r_idx : r_idx + 6'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
